// File: rtl/cmos_byte_packer.sv
// Packs a sensor byte stream into BPP-byte pixel words in the pclk domain.
// Also produces SOF/EOL markers, per-line pixel counts and fragment-error detection.
module cmos_byte_packer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BPP    = 2,
  parameter int unsigned CNT_W  = 12
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    vs_i,
  input  logic                    de_i,
  input  logic [DATA_W-1:0]       pdata_i,
  input  logic                    swap_i,
  output logic                    pix_valid_o,
  output logic [BPP*DATA_W-1:0]   pix_data_o,
  output logic                    sof_o,
  output logic                    eol_o,
  output logic [CNT_W-1:0]        line_px_o,
  output logic                    frag_err_o
);

  localparam int unsigned PW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int unsigned WW = BPP * DATA_W;
  localparam logic [PW-1:0] LAST = PW'(BPP - 1);

  logic             vs_q, de_q;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WW-1:0]    acc_q, acc_d;
  logic             done_q, done_d;
  logic [WW-1:0]    word_q, word_d;
  logic             swap_q, swap_d;
  logic             sof_pend_q, sof_pend_d;
  logic [CNT_W-1:0] px_cnt_q, px_cnt_d;
  logic             eol_pend_q, eol_pend_d;
  logic             pix_valid_q, pix_valid_d;
  logic [WW-1:0]    pix_data_q, pix_data_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic [CNT_W-1:0] line_px_q, line_px_d;
  logic             frag_q, frag_d;

  logic             frame_start, line_end, capture, last_byte;
  logic [WW-1:0]    assembled;
  int unsigned      ph;

  always_comb begin
    frame_start = vs_i & ~vs_q;
    line_end    = de_q & ~de_i;
    capture     = de_i & ~frame_start;
    last_byte   = (phase_q == LAST);
    ph          = 32'(phase_q);

    assembled = acc_q;
    for (int unsigned k = 0; k < BPP; k++) begin
      if (k == (swap_q ? ph : (BPP - 1 - ph))) begin
        assembled[k*DATA_W +: DATA_W] = pdata_i;
      end
    end

    phase_d     = phase_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    word_d      = word_q;
    swap_d      = swap_q;
    sof_pend_d  = sof_pend_q;
    px_cnt_d    = px_cnt_q;
    eol_pend_d  = line_end;
    pix_valid_d = done_q;
    pix_data_d  = pix_data_q;
    sof_d       = 1'b0;
    eol_d       = eol_pend_q;
    line_px_d   = line_px_q;
    frag_d      = frag_q;

    // A completed pixel is published (and counted) one cycle after its last byte.
    if (done_q) begin
      pix_data_d = word_q;
      sof_d      = sof_pend_q;
      sof_pend_d = 1'b0;
      if (px_cnt_q != '1) px_cnt_d = px_cnt_q + 1'b1;
    end

    if (capture) begin
      acc_d = assembled;
      if (last_byte) begin
        phase_d = '0;
        done_d  = 1'b1;
        word_d  = assembled;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    // done_q marks a pixel not yet folded into px_cnt; include it in the line total.
    if (line_end) begin
      line_px_d = (done_q && (px_cnt_q != '1)) ? px_cnt_q + 1'b1 : px_cnt_q;
      px_cnt_d  = '0;
      if (phase_q != '0) begin
        frag_d  = 1'b1;
        phase_d = '0;
      end
    end

    if (frame_start) begin
      phase_d    = '0;
      sof_pend_d = 1'b1;
      frag_d     = 1'b0;
      px_cnt_d   = '0;
      swap_d     = swap_i;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      phase_q     <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      word_q      <= '0;
      swap_q      <= 1'b0;
      sof_pend_q  <= 1'b0;
      px_cnt_q    <= '0;
      eol_pend_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      line_px_q   <= '0;
      frag_q      <= 1'b0;
    end else begin
      vs_q        <= vs_i;
      de_q        <= de_i;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      word_q      <= word_d;
      swap_q      <= swap_d;
      sof_pend_q  <= sof_pend_d;
      px_cnt_q    <= px_cnt_d;
      eol_pend_q  <= eol_pend_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      line_px_q   <= line_px_d;
      frag_q      <= frag_d;
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign pix_data_o  = pix_data_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;
  assign line_px_o   = line_px_q;
  assign frag_err_o  = frag_q;

endmodule

// File: tb/tb_cmos_byte_packer.sv
// Directed bench for cmos_byte_packer: four instances (BPP 1..4) share one stimulus bus,
// each table row names which instance's outputs it checks.
module tb_cmos_byte_packer;

  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;

  logic       pclk = 1'b0;
  logic       rst, vs, de, swap;
  logic [7:0] pdata;

  logic        v1, s1, e1, f1;
  logic [7:0]  d1;
  logic [3:0]  l1;
  logic        v2, s2, e2, f2;
  logic [15:0] d2;
  logic [11:0] l2;
  logic        v3, s3, e3, f3;
  logic [23:0] d3;
  logic [11:0] l3;
  logic        v4, s4, e4, f4;
  logic [31:0] d4;
  logic [11:0] l4;

  always #5 pclk = ~pclk;

  cmos_byte_packer #(.DATA_W(8), .BPP(1), .CNT_W(4)) u1 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pdata), .swap_i(swap),
    .pix_valid_o(v1), .pix_data_o(d1), .sof_o(s1), .eol_o(e1), .line_px_o(l1), .frag_err_o(f1));
  cmos_byte_packer #(.DATA_W(8), .BPP(2), .CNT_W(12)) u2 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pdata), .swap_i(swap),
    .pix_valid_o(v2), .pix_data_o(d2), .sof_o(s2), .eol_o(e2), .line_px_o(l2), .frag_err_o(f2));
  cmos_byte_packer #(.DATA_W(8), .BPP(3), .CNT_W(12)) u3 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pdata), .swap_i(swap),
    .pix_valid_o(v3), .pix_data_o(d3), .sof_o(s3), .eol_o(e3), .line_px_o(l3), .frag_err_o(f3));
  cmos_byte_packer #(.DATA_W(8), .BPP(4), .CNT_W(12)) u4 (
    .pclk(pclk), .rst(rst), .vs_i(vs), .de_i(de), .pdata_i(pdata), .swap_i(swap),
    .pix_valid_o(v4), .pix_data_o(d4), .sof_o(s4), .eol_o(e4), .line_px_o(l4), .frag_err_o(f4));

  typedef struct {
    logic        rst, vs, de;
    logic [7:0]  d;
    logic        sw;
    int          dut;
    logic        ev;
    logic [31:0] ed;
    logic        es, ee;
    logic [11:0] el;
    logic        ef;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   cur_dut = 0;

  logic        got_v, got_s, got_e, got_f;
  logic [31:0] got_d;
  logic [11:0] got_l;

  always_comb begin
    got_v = 1'b0; got_s = 1'b0; got_e = 1'b0; got_f = 1'b0;
    got_d = '0;   got_l = '0;
    case (cur_dut)
      1: begin got_v = v1; got_d = {24'h0, d1}; got_s = s1; got_e = e1; got_l = {8'h0, l1}; got_f = f1; end
      2: begin got_v = v2; got_d = {16'h0, d2}; got_s = s2; got_e = e2; got_l = l2; got_f = f2; end
      3: begin got_v = v3; got_d = {8'h0, d3};  got_s = s3; got_e = e3; got_l = l3; got_f = f3; end
      4: begin got_v = v4; got_d = d4;          got_s = s4; got_e = e4; got_l = l4; got_f = f4; end
      default: ;
    endcase
  end

  task automatic add(input logic r, input logic v, input logic e, input logic [7:0] d,
                     input logic sw, input int dut, input logic ev, input logic [31:0] ed,
                     input logic es, input logic ee, input logic [11:0] el, input logic ef);
    vec_t t;
    t.rst = r; t.vs = v; t.de = e; t.d = d; t.sw = sw; t.dut = dut;
    t.ev = ev; t.ed = ed; t.es = es; t.ee = ee; t.el = el; t.ef = ef;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic e, input logic [7:0] d);
    rst = r; vs = v; de = e; pdata = d; swap = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic        seen;
    int          lat;
    logic [31:0] lat_data;
    logic        lat_sof;

    rst = 1'b1; vs = 1'b0; de = 1'b0; pdata = 8'h00; swap = 1'b0;

    // reset state of every instance
    add(Y,N,N,8'h00,N,1, N,32'h0,N,N,12'd0,N);
    add(Y,N,N,8'h00,N,2, N,32'h0,N,N,12'd0,N);
    add(Y,N,N,8'h00,N,3, N,32'h0,N,N,12'd0,N);
    add(Y,N,N,8'h00,N,4, N,32'h0,N,N,12'd0,N);

    // BPP=2, swap=0
    add(N,Y,N,8'h00,N,2, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h12,N,2, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h34,N,2, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h56,N,2, Y,32'h1234,Y,N,12'd0,N);
    add(N,Y,Y,8'h78,N,2, N,32'h1234,N,N,12'd0,N);
    add(N,Y,N,8'h00,N,2, Y,32'h5678,N,N,12'd2,N);
    add(N,Y,N,8'h00,N,2, N,32'h5678,N,Y,12'd2,N);
    add(N,N,N,8'h00,Y,2, N,32'h5678,N,N,12'd2,N);
    // BPP=2, swap=1 latched at frame start, then dropped back to 0 mid-frame
    add(N,Y,N,8'h00,Y,2, N,32'h5678,N,N,12'd2,N);
    add(N,Y,Y,8'h12,N,2, N,32'h5678,N,N,12'd2,N);
    add(N,Y,Y,8'h34,N,2, N,32'h5678,N,N,12'd2,N);
    add(N,Y,Y,8'h56,N,2, Y,32'h3412,Y,N,12'd2,N);
    add(N,Y,Y,8'h78,N,2, N,32'h3412,N,N,12'd2,N);
    add(N,Y,N,8'h00,N,2, Y,32'h7856,N,N,12'd2,N);
    add(N,Y,N,8'h00,N,2, N,32'h7856,N,Y,12'd2,N);
    add(N,N,N,8'h00,N,2, N,32'h7856,N,N,12'd2,N);
    // BPP=2 fragment: 5 bytes, then next frame start clears the flag
    add(N,Y,N,8'h00,N,2, N,32'h7856,N,N,12'd2,N);
    add(N,Y,Y,8'h01,N,2, N,32'h7856,N,N,12'd2,N);
    add(N,Y,Y,8'h02,N,2, N,32'h7856,N,N,12'd2,N);
    add(N,Y,Y,8'h03,N,2, Y,32'h0102,Y,N,12'd2,N);
    add(N,Y,Y,8'h04,N,2, N,32'h0102,N,N,12'd2,N);
    add(N,Y,Y,8'h05,N,2, Y,32'h0304,N,N,12'd2,N);
    add(N,Y,N,8'h00,N,2, N,32'h0304,N,N,12'd2,Y);
    add(N,Y,N,8'h00,N,2, N,32'h0304,N,Y,12'd2,Y);
    add(N,N,N,8'h00,N,2, N,32'h0304,N,N,12'd2,Y);
    add(N,Y,N,8'h00,N,2, N,32'h0304,N,N,12'd2,N);

    // BPP=3, bytes A1..A6
    add(Y,N,N,8'h00,N,3, N,32'h0,N,N,12'd0,N);
    add(N,Y,N,8'h00,N,3, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'hA1,N,3, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'hA2,N,3, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'hA3,N,3, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'hA4,N,3, Y,32'hA1A2A3,Y,N,12'd0,N);
    add(N,Y,Y,8'hA5,N,3, N,32'hA1A2A3,N,N,12'd0,N);
    add(N,Y,Y,8'hA6,N,3, N,32'hA1A2A3,N,N,12'd0,N);
    add(N,Y,N,8'h00,N,3, Y,32'hA4A5A6,N,N,12'd2,N);
    add(N,Y,N,8'h00,N,3, N,32'hA4A5A6,N,Y,12'd2,N);

    // BPP=4: two bytes, frame start on byte 3, then four fresh bytes
    add(Y,N,N,8'h00,N,4, N,32'h0,N,N,12'd0,N);
    add(N,N,Y,8'h11,N,4, N,32'h0,N,N,12'd0,N);
    add(N,N,Y,8'h22,N,4, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h33,N,4, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h44,N,4, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h55,N,4, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h66,N,4, N,32'h0,N,N,12'd0,N);
    add(N,Y,Y,8'h77,N,4, N,32'h0,N,N,12'd0,N);
    add(N,Y,N,8'h00,N,4, Y,32'h44556677,Y,N,12'd1,N);
    add(N,Y,N,8'h00,N,4, N,32'h44556677,N,Y,12'd1,N);

    // BPP=1, CNT_W=4: pre-frame byte (no sof), then 20-byte line saturating at 15
    add(Y,N,N,8'h00,N,1, N,32'h0,N,N,12'd0,N);
    add(N,N,Y,8'h5A,N,1, N,32'h0,N,N,12'd0,N);
    add(N,N,N,8'h00,N,1, Y,32'h5A,N,N,12'd1,N);
    add(N,N,N,8'h00,N,1, N,32'h5A,N,Y,12'd1,N);
    add(N,Y,N,8'h00,N,1, N,32'h5A,N,N,12'd1,N);
    for (int k = 1; k <= 20; k++)
      add(N,Y,Y,8'(k),N,1, (k >= 2), (k >= 2) ? 32'(k - 1) : 32'h5A, (k == 2), N, 12'd1, N);
    add(N,Y,N,8'h00,N,1, Y,32'h14,N,N,12'd15,N);
    add(N,Y,N,8'h00,N,1, N,32'h14,N,Y,12'd15,N);
    for (int k = 1; k <= 9; k++)
      add(N,Y,Y,8'(k),N,1, (k >= 2), (k >= 2) ? 32'(k - 1) : 32'h14, N, N, 12'd15, N);
    add(Y,Y,Y,8'h0A,N,1, N,32'h0,N,N,12'd0,N);
    add(N,N,N,8'h00,N,1, N,32'h0,N,N,12'd0,N);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; vs = vecs[i].vs; de = vecs[i].de;
      pdata = vecs[i].d; swap = vecs[i].sw; cur_dut = vecs[i].dut;
      @(posedge pclk);
      #1;
      tests++;
      if ({got_v, got_d, got_s, got_e, got_l, got_f} !==
          {vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].ee, vecs[i].el, vecs[i].ef}) begin
        fails++;
        $display("FAIL row%0d dut%0d: got v=%b d=%h sof=%b eol=%b lpx=%0d err=%b, expected v=%b d=%h sof=%b eol=%b lpx=%0d err=%b",
                 i, vecs[i].dut, got_v, got_d, got_s, got_e, got_l, got_f,
                 vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].ee, vecs[i].el, vecs[i].ef);
      end
    end

    // BPP=2: frame start coincident with a mid-pixel line end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b0, 1'b1, 8'hBB);
    drive(1'b0, 1'b0, 1'b1, 8'hCC);
    chk("pre_frame_px", {15'h0, v2, d2}, {15'h0, 1'b1, 16'hAABB});
    chk("pre_frame_sof", 32'(s2), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fs_le_err", 32'(f2), 32'h0);
    chk("fs_le_lpx", 32'(l2), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fs_le_eol", 32'(e2), 32'h1);
    drive(1'b0, 1'b1, 1'b1, 8'hDD);
    drive(1'b0, 1'b1, 1'b1, 8'hEE);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fs_le_next_px", {14'h0, v2, s2, d2}, {14'h0, 1'b1, 1'b1, 16'hDDEE});

    // BPP=3: bounded wait for the strobe after the last byte
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h10);
    drive(1'b0, 1'b1, 1'b1, 8'h20);
    drive(1'b0, 1'b1, 1'b1, 8'h30);
    seen = 1'b0; lat = 0; lat_data = '0; lat_sof = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      if (v3) begin
        seen = 1'b1; lat = c; lat_data = {8'h0, d3}; lat_sof = s3;
      end
    end
    chk("lat3_seen", 32'(seen), 32'h1);
    chk("lat3_cycles", 32'(lat), 32'd1);
    chk("lat3_data", lat_data, 32'h102030);
    chk("lat3_sof", 32'(lat_sof), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
